// File: rtl/led_scan_decoder.sv
// led_scan_decoder
//   Time-multiplexed digit scanner for seven-segment / LED displays. A
//   prescaler divides clk into slots of TICK_DIV cycles. Each slot selects
//   one of NUM = 2**SEL_W digits. The active digit's anode is driven low and
//   its segment pattern is presented. The first BLANK cycles of every slot
//   are forced dark as an anti-ghosting dead time.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset (dominant)
//   enable      1 = scan runs, 0 = counters hold and outputs blank
//   mask        per-digit enable, 1 = digit shown
//   data_in     segment patterns, digit i at [i*SEG_W +: SEG_W]
//   an          anode enables, active-low one-hot or all-ones
//   sseg        segment drive, active-low
//   cur         current slot index
//   frame_tick  one-cycle pulse when cur wraps from NUM-1 to 0
//
// Legal parameter ranges: SEL_W >= 1, TICK_DIV >= 2, 0 <= BLANK < TICK_DIV.

module led_scan_decoder #(
  parameter int SEL_W    = 2,
  parameter int SEG_W    = 8,
  parameter int TICK_DIV = 50000,
  parameter int BLANK    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [(2**SEL_W)-1:0]       mask,
  input  logic [(2**SEL_W)*SEG_W-1:0] data_in,
  output logic [(2**SEL_W)-1:0]       an,
  output logic [SEG_W-1:0]            sseg,
  output logic [SEL_W-1:0]            cur,
  output logic                        frame_tick
);

  localparam int NUM  = 2**SEL_W;
  localparam int PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] CUR_LAST = '1;

  logic [PC_W-1:0]  pc;
  logic             in_dead;
  logic             blank_now;
  logic [NUM-1:0]   an_dec;
  logic [SEG_W-1:0] seg_sel;

  // With BLANK == 0 the dead-time compare would be constant false; build it
  // only when there is a dead time to enforce.
  generate
    if (BLANK == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (pc < PC_W'(BLANK));
    end
  endgenerate

  assign blank_now = !enable || !mask[cur] || in_dead;

  // Generalised SEL_W-to-NUM decoder, active-low.
  assign an_dec = ~(NUM'(1) << cur);

  always_comb begin
    seg_sel = '1;
    for (int i = 0; i < NUM; i++) begin
      if (cur == SEL_W'(i)) begin
        seg_sel = data_in[i*SEG_W +: SEG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      cur        <= '0;
      an         <= '1;
      sseg       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (enable) begin
        if (pc == PC_LAST) begin
          pc         <= '0;
          // NUM is a power of two, so the natural wrap of cur is mod NUM.
          cur        <= cur + 1'b1;
          frame_tick <= (cur == CUR_LAST);
        end else begin
          pc <= pc + 1'b1;
        end
      end

      // Outputs reflect the pre-edge slot, so they lag cur by one cycle.
      if (blank_now) begin
        an   <= '1;
        sseg <= '1;
      end else begin
        an   <= an_dec;
        sseg <= seg_sel;
      end
    end
  end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Parametrised, time-multiplexed successor to the team's combinational 2-to-4 and 3-to-8 decoders.
- Cycles a select index through 2**SEL_W digit slots at a programmable refresh rate and drives active-low one-hot anode enables plus the segment pattern for the active slot.
- Adds per-digit masking, anti-ghosting dead time and a frame-wrap pulse.
- Sits between display-data registers and the board's seven-segment/LED pins.

Parameters:
SEL_W, 2, select width; digit count NUM = 2**SEL_W; legal range >= 1
SEG_W, 8, segment bits per digit, active-low, dp included
TICK_DIV, 50000, clk cycles per digit slot; legal range >= 2
BLANK, 0, dead-time cycles at the start of each slot with all outputs blank; legal range 0 <= BLANK < TICK_DIV

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  scan run/blank control
mask  in  NUM  per-digit enable; 1 = digit shown
data_in  in  NUM*SEG_W  segment patterns; digit i at [i*SEG_W +: SEG_W]
an  out  NUM  anode enables, active-low one-hot or all-ones
sseg  out  SEG_W  segment drive, active-low
cur  out  SEL_W  current slot index, registered
frame_tick  out  1  one-cycle pulse on slot wrap

Behaviour:
- State:
  - prescaler pc, width clog2(TICK_DIV), counts 0..TICK_DIV-1.
  - cur.
  - output registers an, sseg, frame_tick.
- Reset, synchronous and dominant over all inputs: pc=0, cur=0, an=all 1, sseg=all 1, frame_tick=0.
- Counting while enable=1:
  - pc<TICK_DIV-1: pc+1.
  - pc==TICK_DIV-1: pc=0 and cur=cur+1 mod NUM, so NUM-1 wraps to 0.
- While enable=0: pc and cur hold. On re-enable, counting resumes from the held values; the slot is not restarted.
- frame_tick:
  - Registered; 1 for exactly one cycle, on the same edge that loads cur 0 from NUM-1.
  - 0 at all other times, and 0 while enable=0.
- Outputs are registered from the pre-edge values of enable, mask, cur, pc and data_in (1-cycle latency).
  - Blank condition = !enable | !mask[cur] | (pc < BLANK).
  - Blank: an = all 1, sseg = all 1.
  - Otherwise: an = ~(1<<cur), sseg = data_in slice for cur.
- Masked digits keep their full slot duration with blank output; slots are never skipped, so the duty cycle is independent of mask.
- mask=0: outputs permanently blank; cur and frame_tick keep running.
- Changes to data_in or mask mid-slot are reflected on the outputs one cycle later. No glitch beyond the registered output.
- Never more than one an bit low.
- Decode of cur to an is the generalised SEL_W-to-NUM decoder. No latches, no combinational output paths.

Test Plan:
1. Slot sequence. Params SEL_W=2, TICK_DIV=4, BLANK=1. Stimulus: reset, then enable=1, mask=4'b1111, data_in=32'h44332211. Required per-cycle an after reset: 1111 (blank), 1110 x3 with sseg=8'h11, 1111, 1101 x3 with sseg=8'h22, 1111, 1011 x3 with 8'h33, 1111, 0111 x3 with 8'h44, then repeats.
2. Frame pulse. Same setup as 1, 64 cycles. Required: frame_tick high exactly one cycle every 16 cycles, coincident with cur becoming 0; never two consecutive highs.
3. Masking. mask=4'b0101, same params. Required: slots 1 and 3 show an=1111 and sseg=8'hFF for all 4 cycles; slots 0 and 2 are unchanged from test 1; frame period is still 16.
4. Enable drop mid-slot. Drop enable at pc=2 of slot 1 for 5 cycles. Required: outputs blank from the next cycle; cur=1 and pc held. On re-enable, an=1101 returns 1 cycle later (pc=2 is not <BLANK) and stays for the 2 remaining cycles (pc=2,3), then advances to slot 2 as normal; no frame_tick while disabled.
5. Reset mid-operation. Assert reset for 1 cycle at cur=2, pc=3, enable=1. Required: next cycle an=1111, sseg=8'hFF, cur=0, frame_tick=0; sequence restarts exactly as in test 1.
6. Wide variant. Params SEL_W=3, TICK_DIV=2, BLANK=0, mask=8'hFF. Required: an walks 11111110 through 01111111, each pattern 2 cycles; frame_tick every 16 cycles. A data_in change of digit 5 mid-slot appears on sseg 1 cycle later.
